scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 The block SHALL have parameter PRESC_WIDTH, default 16, giving the width of the prescaler divider.
REQ-002 The block SHALL have parameter COUNTER_WIDTH, default 8, matching the width of the downstream bounce-shifter period counter.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, listed first in the port list:
- clk  input  1  single clock; all logic on its rising edge.
- rstna  input  1  asynchronous reset, active low.
REQ-004 The block SHALL have the following control inputs:
- start  input  1  one-cycle request to begin a scan.
- stop  input  1  one-cycle request to abort a scan.
- hold  input  1  level; freezes the scan while high.
- presc_div  input  PRESC_WIDTH  tick period minus 1, in clk cycles.
- target_periods  input  COUNTER_WIDTH  bounces to run; 0 means run forever.
- period_count  input  COUNTER_WIDTH  period counter from the bounce shifter.
REQ-005 The block SHALL have the following outputs:
- ena  output  1  one-cycle shift-enable pulse to the bounce shifter.
- busy  output  1  high in RUN and HOLD.
- done  output  1  one-cycle pulse when the target is reached.
- state  output  2  current FSM state.

Function
REQ-006 The FSM SHALL have four states: IDLE=0, RUN=1, HOLD=2, FINISH=3.
REQ-007 In IDLE, when start=1 and stop=0, the block SHALL latch presc_div, target_periods and period_count (as the base count), clear the prescaler, and enter RUN.
REQ-008 In RUN, the prescaler SHALL count 0..div_q and wrap to 0. On every edge where the count equals div_q, ena SHALL be registered high for exactly one cycle.
REQ-009 With div_q=D, the first ena high cycle SHALL begin D+1 edges after the start edge, and ena SHALL repeat every D+1 cycles. With D=0, ena SHALL be high on every RUN cycle after the first.
REQ-010 presc_div and target_periods changes during RUN or HOLD SHALL have no effect until the next start.
REQ-011 The elapsed count SHALL be period_count minus the base count, computed modulo 2^COUNTER_WIDTH so that counter wrap is handled.
REQ-012 In RUN with target_q≠0 and elapsed==target_q, the block SHALL enter FINISH on the next edge with ena forced 0.
REQ-013 In FINISH, the block SHALL assert done for exactly that cycle and then return to IDLE.
REQ-014 In RUN with hold=1, the block SHALL enter HOLD. In HOLD:
- the prescaler SHALL be frozen and ena SHALL be 0;
- when hold returns to 0, the block SHALL return to RUN and the prescaler SHALL resume from its frozen value.
REQ-015 stop=1 in RUN or HOLD SHALL return the FSM to IDLE on the next edge, with ena=0 and done=0. stop SHALL take priority over start, hold and completion.
REQ-016 start outside IDLE SHALL be ignored. stop in IDLE or FINISH SHALL be ignored.
REQ-017 When completion and hold are both true in the same RUN cycle, completion SHALL win and the FSM SHALL go to FINISH.
REQ-018 ena SHALL never be high in IDLE, HOLD or FINISH. ena and done SHALL never be high in the same cycle.
REQ-019 busy SHALL equal (state==RUN or state==HOLD), decoded from registered state only.

Reset
REQ-020 While rstna=0, the block SHALL asynchronously hold: state=IDLE, ena=0, busy=0, done=0, prescaler=0, div_q=0, target_q=0, base count=0.
REQ-021 Reset asserted mid-scan SHALL abort immediately, with no done pulse.
REQ-022 After rstna deasserts, the block SHALL remain in IDLE until the first start.

Structure
REQ-023 The state encodings SHALL live in a shared package scan_pkg, together with the default PRESC_WIDTH and COUNTER_WIDTH constants.
REQ-024 The prescaler SHALL be a sub-module tick_prescaler with inputs clk, rstna, clr, run, div and output tick.
REQ-025 The FSM, the latches and the elapsed compare SHALL reside in scan_ctrl.

Verification
REQ-026 Basic tick spacing: presc_div=3, target_periods=0, start at cycle 10 -> ena high at cycles 14, 18, 22, ...; busy=1 from cycle 11.
REQ-027 Completion: presc_div=0, target_periods=2, base period_count=5; drive period_count to 7 -> FINISH next edge, done=1 for 1 cycle, then IDLE; no ena after elapsed reaches 2.
REQ-028 Counter wrap: base period_count=254, target_periods=3; period_count goes 255, 0, 1 -> done fires when period_count=1.
REQ-029 Hold: presc_div=4; hold high for 7 cycles when prescaler=2 -> no ena during HOLD; after release, the next ena comes 3 cycles later.
REQ-030 Stop priority: stop and start together in RUN -> IDLE, no done; stop and completion in the same cycle -> IDLE, done=0.
REQ-031 Reset mid-run: rstna low during RUN at prescaler=1 -> all outputs 0 and state=IDLE immediately; after release, no ena until the next start.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared FSM state encoding and default widths for the scan controller
package scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, FINISH = 2'd3} state_t;
  localparam int PRESC_WIDTH_DEF = 16;
  localparam int COUNTER_WIDTH_DEF = 8;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..div and wraps, flagging the wrap cycle as tick
// ports: clk, rstna (async, active low), clr (sync clear), run (advance enable),
//        div (terminal count), tick (combinational, high when running at terminal count)
module tick_prescaler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstna,
  input  logic             clr,
  input  logic             run,
  input  logic [WIDTH-1:0] div,
  output logic             tick
);
  logic [WIDTH-1:0] cnt;
  assign tick = run && cnt == div;
  always_ff @(posedge clk or negedge rstna)
    if (!rstna) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: start/stop/hold scan FSM pacing a bounce shifter with ena pulses
// ports: clk, rstna (async, active low), start/stop (pulses), hold (level),
//        presc_div, target_periods, period_count (inputs latched on start),
//        ena (shift pulse), busy (RUN or HOLD), done (completion pulse), state
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int PRESC_WIDTH = PRESC_WIDTH_DEF,
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstna,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     hold,
  input  logic [PRESC_WIDTH-1:0]   presc_div,
  input  logic [COUNTER_WIDTH-1:0] target_periods,
  input  logic [COUNTER_WIDTH-1:0] period_count,
  output logic                     ena,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state
);
  state_t st;
  logic [PRESC_WIDTH-1:0] div_q;
  logic [COUNTER_WIDTH-1:0] target_q, base_q, elapsed;
  logic go, complete, run, tick;
  assign go = st == IDLE && start && !stop;
  // modular subtraction absorbs wrap of the shifter's period counter
  assign elapsed = period_count - base_q;
  assign complete = target_q != '0 && elapsed == target_q;
  // freeze the prescaler on any edge that leaves RUN so a hold resumes exactly where it stopped
  assign run = st == RUN && !stop && !complete && !hold;
  assign busy = st == RUN || st == HOLD;
  assign state = st;
  tick_prescaler #(.WIDTH(PRESC_WIDTH)) u_presc (
    .clk  (clk),
    .rstna(rstna),
    .clr  (go),
    .run  (run),
    .div  (div_q),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rstna)
    if (!rstna) begin
      st <= IDLE;
      ena <= 1'b0;
      done <= 1'b0;
      div_q <= '0;
      target_q <= '0;
      base_q <= '0;
    end else begin
      ena <= 1'b0;
      done <= 1'b0;
      case (st)
        IDLE: if (go) begin
          st <= RUN;
          div_q <= presc_div;
          target_q <= target_periods;
          base_q <= period_count;
        end
        RUN: if (stop) st <= IDLE;
        else if (complete) begin
          st <= FINISH;
          done <= 1'b1;
        end else if (hold) st <= HOLD;
        else ena <= tick;
        HOLD: st <= stop ? IDLE : hold ? HOLD : RUN;
        FINISH: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: directed scoreboard bench for scan_ctrl
module tb_scan_ctrl;
  logic clk, rstna, start, stop, hold;
  logic [15:0] presc_div;
  logic [7:0] target_periods, period_count;
  logic ena, busy, done;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string tag;
    logic [4:0] v;
  } exp_t;
  exp_t sb[$];
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2, S_FIN = 2'd3;

  scan_ctrl dut (
    .clk(clk), .rstna(rstna), .start(start), .stop(stop), .hold(hold),
    .presc_div(presc_div), .target_periods(target_periods), .period_count(period_count),
    .ena(ena), .busy(busy), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] o(input logic e, input logic b, input logic d, input logic [1:0] s);
    return {e, b, d, s};
  endfunction

  task automatic compare_front();
    exp_t e;
    logic [4:0] obs;
    e = sb.pop_front();
    obs = {ena, busy, done, state};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed {ena,busy,done,state}=%b expected %b", e.tag, obs, e.v);
    end
  endtask

  task automatic now_chk(input string tag, input logic [4:0] v);
    sb.push_back('{tag, v});
    compare_front();
  endtask

  task automatic edge_chk(input string tag, input logic [4:0] v);
    sb.push_back('{tag, v});
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    rstna = 1'b0; start = 0; stop = 0; hold = 0;
    presc_div = '0; target_periods = '0; period_count = '0;
    #1;
    now_chk("reset_async", o(0, 0, 0, S_IDLE));
    edge_chk("reset_held", o(0, 0, 0, S_IDLE));
    edge_chk("reset_held2", o(0, 0, 0, S_IDLE));
    rstna = 1'b1;
    repeat (3) edge_chk("idle_after_reset", o(0, 0, 0, S_IDLE));

    // tick spacing with D=3, run forever; later changes to presc_div and start ignored
    presc_div = 16'd3; target_periods = 8'd0; period_count = 8'd0;
    start = 1;
    edge_chk("start_run", o(0, 1, 0, S_RUN));
    start = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) presc_div = 16'd0;
      start = (k == 6);
      edge_chk($sformatf("spacing_k%0d", k), o(k % 4 == 0, 1, 0, S_RUN));
    end
    start = 1; stop = 1;
    edge_chk("stop_beats_start", o(0, 0, 0, S_IDLE));
    start = 0;
    edge_chk("stop_in_idle", o(0, 0, 0, S_IDLE));
    stop = 0;

    // completion: D=0, target 2 from base 5
    presc_div = 16'd0; target_periods = 8'd2; period_count = 8'd5;
    start = 1;
    edge_chk("cmp_start", o(0, 1, 0, S_RUN));
    start = 0;
    edge_chk("cmp_ena_d0", o(1, 1, 0, S_RUN));
    period_count = 8'd6;
    edge_chk("cmp_elapsed1", o(1, 1, 0, S_RUN));
    period_count = 8'd7;
    edge_chk("cmp_finish", o(0, 0, 1, S_FIN));
    edge_chk("cmp_idle", o(0, 0, 0, S_IDLE));
    edge_chk("cmp_idle2", o(0, 0, 0, S_IDLE));

    // counter wrap: base 254, target 3
    presc_div = 16'd1; target_periods = 8'd3; period_count = 8'd254;
    start = 1;
    edge_chk("wrap_start", o(0, 1, 0, S_RUN));
    start = 0; period_count = 8'd255;
    edge_chk("wrap_255", o(0, 1, 0, S_RUN));
    period_count = 8'd0;
    edge_chk("wrap_0", o(1, 1, 0, S_RUN));
    period_count = 8'd1;
    edge_chk("wrap_done", o(0, 0, 1, S_FIN));
    edge_chk("wrap_idle", o(0, 0, 0, S_IDLE));

    // hold at prescaler=2 with D=4
    presc_div = 16'd4; target_periods = 8'd0;
    start = 1;
    edge_chk("hold_start", o(0, 1, 0, S_RUN));
    start = 0;
    edge_chk("hold_p1", o(0, 1, 0, S_RUN));
    edge_chk("hold_p2", o(0, 1, 0, S_RUN));
    hold = 1;
    for (int k = 0; k < 7; k++) edge_chk($sformatf("hold_in_%0d", k), o(0, 1, 0, S_HOLD));
    hold = 0;
    edge_chk("hold_release", o(0, 1, 0, S_RUN));
    edge_chk("hold_resume1", o(0, 1, 0, S_RUN));
    edge_chk("hold_resume2", o(0, 1, 0, S_RUN));
    edge_chk("hold_resume_ena", o(1, 1, 0, S_RUN));
    hold = 1;
    edge_chk("hold_again", o(0, 1, 0, S_HOLD));
    stop = 1;
    edge_chk("stop_in_hold", o(0, 0, 0, S_IDLE));
    stop = 0; hold = 0;

    // stop together with completion
    presc_div = 16'd0; target_periods = 8'd1; period_count = 8'd10;
    start = 1;
    edge_chk("stopcmp_start", o(0, 1, 0, S_RUN));
    start = 0; period_count = 8'd11; stop = 1;
    edge_chk("stop_beats_done", o(0, 0, 0, S_IDLE));
    stop = 0;
    edge_chk("stop_beats_done_idle", o(0, 0, 0, S_IDLE));

    // completion together with hold
    period_count = 8'd20;
    start = 1;
    edge_chk("cmphold_start", o(0, 1, 0, S_RUN));
    start = 0; period_count = 8'd21; hold = 1;
    edge_chk("done_beats_hold", o(0, 0, 1, S_FIN));
    hold = 0;
    edge_chk("done_beats_hold_idle", o(0, 0, 0, S_IDLE));

    // reset mid-run at prescaler=1
    presc_div = 16'd5; target_periods = 8'd0;
    start = 1;
    edge_chk("rst_run_start", o(0, 1, 0, S_RUN));
    start = 0;
    edge_chk("rst_run_p1", o(0, 1, 0, S_RUN));
    #2 rstna = 1'b0;
    #1;
    now_chk("rst_mid_async", o(0, 0, 0, S_IDLE));
    edge_chk("rst_mid_held", o(0, 0, 0, S_IDLE));
    rstna = 1'b1;
    for (int k = 0; k < 8; k++) edge_chk($sformatf("rst_mid_after_%0d", k), o(0, 0, 0, S_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
